tile_ram_cmd_ctrl: RTL and testbench

Command sequencer that owns the write port of the 1024-byte tile RAM behind the video generator. It consumes the byte stream from the COBS decoder, where each decoded packet is one command. It then issues single-byte RAM writes, fills or clears. All writes are gated to video blanking so the picture never tears mid-frame.

---
 rtl/tile_ram_cmd_ctrl_pkg.sv | 11 +
 rtl/tile_fill_engine.sv | 72 +++++++
 rtl/tile_ram_cmd_ctrl.sv | 163 ++++++++++++++++
 tb/tb_tile_ram_cmd_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_ram_cmd_ctrl_pkg.sv
// Shared opcodes, sequencer states and RAM geometry for the tile RAM command path.
package tile_ram_cmd_ctrl_pkg;
  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_FILL  = 8'h02;
  localparam logic [7:0] OP_CLEAR = 8'h03;
  localparam int TILE_DEPTH = 1024;

  typedef enum logic [3:0] {
    IDLE, A_HI, A_LO, C_HI, C_LO, VAL, WDATA, RUN, DRAIN
  } state_t;
endpackage

// File: rtl/tile_fill_engine.sv
// Write engine: wrapping address counter, saturating remaining-count, blanking gate.
// Single WRITE bytes and multi-cycle FILL/CLEAR runs share the registered ram_* outputs.
module tile_fill_engine #(
  parameter int ADDR_W  = 10,
  parameter bit GATE_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_allow,
  input  logic              ld_addr,
  input  logic              ld_cnt,
  input  logic              ld_val,
  input  logic              ld_clear,
  input  logic              wr_one,
  input  logic              run,
  input  logic [7:0]        hi,
  input  logic [7:0]        din,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [7:0]        ram_din,
  output logic              rem_zero,
  output logic              done
);
  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] DEPTH = CW'(1) << ADDR_W;

  logic [ADDR_W-1:0] addr;
  logic [CW-1:0]     rem;
  logic [7:0]        val;
  logic [10:0]       raw_cnt;
  logic [CW-1:0]     sat_cnt;
  logic              fire;

  assign raw_cnt  = {hi[2:0], din};
  assign sat_cnt  = ({21'd0, raw_cnt} > 32'(DEPTH)) ? DEPTH : CW'(raw_cnt);
  assign rem_zero = (rem == '0);
  assign fire     = run && (!GATE_EN || wr_allow) && !rem_zero;
  assign done     = fire && (rem == CW'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_we    <= 1'b0;
      ram_waddr <= '0;
      ram_din   <= '0;
      addr      <= '0;
      rem       <= '0;
      val       <= '0;
    end else begin
      ram_we <= fire || wr_one;
      if (ld_clear) begin
        addr <= '0;
        rem  <= DEPTH;
        val  <= 8'h00;
      end else begin
        if (ld_addr) addr <= ADDR_W'({hi, din});
        if (ld_cnt)  rem  <= sat_cnt;
        if (ld_val)  val  <= din;
      end
      // WRITE gating is decided upstream through in_ready, so wr_one is unconditional
      if (wr_one) begin
        ram_waddr <= addr;
        ram_din   <= din;
        addr      <= addr + ADDR_W'(1);
      end else if (fire) begin
        ram_waddr <= addr;
        ram_din   <= val;
        addr      <= addr + ADDR_W'(1);
        rem       <= rem - CW'(1);
      end
    end
  end
endmodule

// File: rtl/tile_ram_cmd_ctrl.sv
// Packet-level command sequencer for the tile RAM write port: parses WRITE/FILL/CLEAR
// packets from the decoded byte stream and drives the fill engine during blanking.
module tile_ram_cmd_ctrl
  import tile_ram_cmd_ctrl_pkg::*;
#(
  parameter int ADDR_W  = $clog2(TILE_DEPTH),
  parameter bit GATE_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              wr_allow,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [7:0]        ram_din,
  output logic              err,
  output logic              busy,
  output logic [7:0]        cmd_count
);
  state_t     state, nstate;
  logic       rdy_en, op_wr, good, good_n, derr, derr_n, err_n, inc;
  logic [7:0] hi;
  logic       hi_ld, op_ld, ld_addr, ld_cnt, ld_val, ld_clear, wr_one;
  logic       rem_zero, done, acc;

  // in_ready stays low for the first cycle after reset release
  always_comb begin
    in_ready = 1'b0;
    if (rdy_en) begin
      case (state)
        RUN:     in_ready = 1'b0;
        WDATA:   in_ready = !GATE_EN || wr_allow;
        default: in_ready = 1'b1;
      endcase
    end
  end

  assign acc  = in_valid && in_ready;
  assign busy = (state == RUN);

  always_comb begin
    nstate   = state;
    err_n    = 1'b0;
    inc      = 1'b0;
    good_n   = good;
    derr_n   = derr;
    hi_ld    = 1'b0;
    op_ld    = 1'b0;
    ld_addr  = 1'b0;
    ld_cnt   = 1'b0;
    ld_val   = 1'b0;
    ld_clear = 1'b0;
    wr_one   = 1'b0;
    case (state)
      IDLE: if (acc) begin
        op_ld = 1'b1;
        if (in_data == OP_WRITE || in_data == OP_FILL) begin
          if (in_last) err_n = 1'b1;
          else         nstate = A_HI;
        end else if (in_data == OP_CLEAR && in_last) begin
          ld_clear = 1'b1;
          good_n   = 1'b1;
          nstate   = RUN;
        end else begin
          err_n  = 1'b1;
          derr_n = 1'b0;
          if (!in_last) nstate = DRAIN;
        end
      end
      A_HI, A_LO, C_HI, C_LO: if (acc) begin
        if (in_last) begin
          err_n  = 1'b1;
          nstate = IDLE;
        end else begin
          case (state)
            A_HI: begin hi_ld = 1'b1; nstate = A_LO; end
            A_LO: begin ld_addr = 1'b1; nstate = op_wr ? WDATA : C_HI; end
            C_HI: begin hi_ld = 1'b1; nstate = C_LO; end
            default: begin ld_cnt = 1'b1; nstate = VAL; end
          endcase
        end
      end
      // A FILL without in_last on VAL still runs; the trailing bytes are drained with an error
      VAL: if (acc) begin
        ld_val = 1'b1;
        good_n = in_last;
        if (!rem_zero) nstate = RUN;
        else if (in_last) begin
          inc    = 1'b1;
          nstate = IDLE;
        end else begin
          derr_n = 1'b1;
          nstate = DRAIN;
        end
      end
      WDATA: if (acc) begin
        wr_one = 1'b1;
        if (in_last) begin
          inc    = 1'b1;
          nstate = IDLE;
        end
      end
      RUN: if (done) begin
        if (good) begin
          inc    = 1'b1;
          nstate = IDLE;
        end else begin
          derr_n = 1'b1;
          nstate = DRAIN;
        end
      end
      DRAIN: if (acc && in_last) begin
        err_n  = derr;
        nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rdy_en    <= 1'b0;
      hi        <= '0;
      op_wr     <= 1'b0;
      good      <= 1'b0;
      derr      <= 1'b0;
      err       <= 1'b0;
      cmd_count <= '0;
    end else begin
      state     <= nstate;
      rdy_en    <= 1'b1;
      good      <= good_n;
      derr      <= derr_n;
      err       <= err_n;
      cmd_count <= cmd_count + {7'd0, inc};
      if (hi_ld) hi    <= in_data;
      if (op_ld) op_wr <= (in_data == OP_WRITE);
    end
  end

  tile_fill_engine #(.ADDR_W(ADDR_W), .GATE_EN(GATE_EN)) u_eng (
    .clk       (clk),
    .rst       (rst),
    .wr_allow  (wr_allow),
    .ld_addr   (ld_addr),
    .ld_cnt    (ld_cnt),
    .ld_val    (ld_val),
    .ld_clear  (ld_clear),
    .wr_one    (wr_one),
    .run       (busy),
    .hi        (hi),
    .din       (in_data),
    .ram_we    (ram_we),
    .ram_waddr (ram_waddr),
    .ram_din   (ram_din),
    .rem_zero  (rem_zero),
    .done      (done)
  );
endmodule

// File: tb/tb_tile_ram_cmd_ctrl.sv
// Bench for tile_ram_cmd_ctrl: directed packets plus random packet streams, checked
// against a packet-level model of the expected RAM writes, errors and good-packet count.
module tb_tile_ram_cmd_ctrl;
  logic       clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_last = 1'b0, wr_allow = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, ram_we, err, busy;
  logic [9:0] ram_waddr;
  logic [7:0] ram_din, cmd_count;

  tile_ram_cmd_ctrl #(.ADDR_W(10), .GATE_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .wr_allow(wr_allow), .ram_we(ram_we), .ram_waddr(ram_waddr),
    .ram_din(ram_din), .err(err), .busy(busy), .cmd_count(cmd_count)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] bq_t[$];
  int n_cmp = 0, n_bad = 0;
  logic [17:0] exp_q[$], got_q[$];
  int got_cyc[$];
  int exp_err, exp_cmd = 0, err_seen, busy_cyc, viol, cyc = 0;
  int allow_mode = 0, ph = 0;
  logic prev_allow = 1'b0;

  // blanking source: 0 = always open, 1 = random, 2 = 10 open / 10 closed
  always @(posedge clk) begin
    #1;
    case (allow_mode)
      0: wr_allow = 1'b1;
      1: wr_allow = 1'($urandom_range(0, 1));
      2: begin wr_allow = (ph < 10); ph = (ph + 1) % 20; end
      default: wr_allow = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    cyc++;
    if (ram_we === 1'b1) begin
      got_q.push_back({ram_waddr, ram_din});
      got_cyc.push_back(cyc);
      if (!prev_allow) viol++;
    end
    if (err === 1'b1) err_seen++;
    if (busy === 1'b1) busy_cyc++;
    prev_allow = wr_allow;
  end

  task automatic clr_mon();
    got_q.delete(); got_cyc.delete(); exp_q.delete();
    err_seen = 0; busy_cyc = 0; viol = 0; exp_err = 0;
  endtask

  // packet-level expectation: list of (addr,data) writes, plus good/bad verdict
  task automatic model_pkt(input bq_t p);
    logic [9:0] a;
    int c, n;
    n = p.size();
    case (p[0])
      8'h01: if (n >= 4) begin
        a = {p[1][1:0], p[2]};
        for (int i = 3; i < n; i++) begin exp_q.push_back({a, p[i]}); a++; end
        exp_cmd++;
      end else exp_err++;
      8'h02: if (n >= 6) begin
        a = {p[1][1:0], p[2]};
        c = {p[3][2:0], p[4]};
        if (c > 1024) c = 1024;
        for (int i = 0; i < c; i++) begin exp_q.push_back({a, p[5]}); a++; end
        if (n == 6) exp_cmd++; else exp_err++;
      end else exp_err++;
      8'h03: if (n == 1) begin
        for (int i = 0; i < 1024; i++) exp_q.push_back({10'(i), 8'h00});
        exp_cmd++;
      end else exp_err++;
      default: exp_err++;
    endcase
  endtask

  task automatic send_pkt(input bq_t p, input int gaps);
    bit ok;
    int t;
    for (int i = 0; i < p.size(); i++) begin
      if (gaps > 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, gaps)) begin @(posedge clk); #1; end
      end
      in_valid = 1'b1; in_data = p[i]; in_last = (i == p.size() - 1);
      t = 0;
      forever begin
        @(negedge clk); ok = in_ready;
        @(posedge clk); #1;
        if (ok) break;
        t++;
        if (t > 5000) begin
          n_cmp++; n_bad++;
          $display("FAIL accept_timeout: byte %0d of pkt op %h not accepted, want accept within 5000 cycles", i, p[0]);
          in_valid = 1'b0; in_last = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy === 1'b1 && t < 20000) begin @(posedge clk); #1; t++; end
    if (t >= 20000) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles, want 0", busy, t);
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst = 1'b0; exp_cmd = 0;
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++;
    if ({in_ready, ram_we, ram_waddr, ram_din, err, busy, cmd_count} !== 30'd0) begin
      n_bad++;
      $display("FAIL reset_state: rdy=%b we=%b addr=%h din=%h err=%b busy=%b cnt=%h, want all 0",
               in_ready, ram_we, ram_waddr, ram_din, err, busy, cmd_count);
    end
    rst = 1'b1;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rdy_at_release: got %b want 0", in_ready); end
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rdy_after_release: got %b want 1", in_ready); end
  endtask

  task automatic test_write();
    bq_t p = '{8'h01, 8'h00, 8'h05, 8'h0A, 8'h0B, 8'h0C};
    allow_mode = 0; clr_mon(); model_pkt(p);
    send_pkt(p, 0); wait_idle();
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL write_n: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL write[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++;
    if (got_cyc.size() != 3 || got_cyc[2] - got_cyc[0] != 2) begin
      n_bad++; $display("FAIL write_back_to_back: got %0d writes spanning %0d cycles, want 3 in 2", got_cyc.size(), got_cyc.size() == 3 ? got_cyc[2] - got_cyc[0] : -1);
    end
    n_cmp++;
    if (cmd_count !== 8'(exp_cmd) || err_seen != 0) begin
      n_bad++; $display("FAIL write_count: cnt=%0d err=%0d want cnt=%0d err=0", cmd_count, err_seen, exp_cmd);
    end
  endtask

  task automatic test_fill_wrap();
    bq_t p = '{8'h02, 8'h03, 8'hFE, 8'h00, 8'h04, 8'h07};
    allow_mode = 0; clr_mon(); model_pkt(p);
    send_pkt(p, 0); wait_idle();
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL fill_n: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL fill[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++;
    if (busy_cyc != 4) begin n_bad++; $display("FAIL fill_busy: got %0d cycles want 4", busy_cyc); end
    n_cmp++;
    if (cmd_count !== 8'(exp_cmd)) begin n_bad++; $display("FAIL fill_count: got %0d want %0d", cmd_count, exp_cmd); end
  endtask

  task automatic test_clear_gated();
    bq_t p = '{8'h03};
    int bad = 0;
    allow_mode = 2; clr_mon(); model_pkt(p);
    send_pkt(p, 0); wait_idle();
    n_cmp++;
    if (got_q.size() !== 1024) begin n_bad++; $display("FAIL clear_n: got %0d want 1024", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++; bad++;
        if (bad < 5) $display("FAIL clear[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (viol != 0) begin n_bad++; $display("FAIL clear_gating: got %0d writes while blanked want 0", viol); end
    n_cmp++;
    if (ram_waddr !== 10'd1023 || cmd_count !== 8'(exp_cmd)) begin
      n_bad++; $display("FAIL clear_end: addr=%0d cnt=%0d want addr=1023 cnt=%0d", ram_waddr, cmd_count, exp_cmd);
    end
  endtask

  task automatic test_bad_opcode();
    bq_t p = '{8'h55, 8'h12, 8'h34};
    allow_mode = 0; clr_mon(); model_pkt(p);
    send_pkt(p, 0); wait_idle();
    n_cmp++;
    if (got_q.size() != 0 || err_seen != 1 || cmd_count !== 8'(exp_cmd)) begin
      n_bad++; $display("FAIL bad_opcode: writes=%0d err=%0d cnt=%0d want 0/1/%0d", got_q.size(), err_seen, cmd_count, exp_cmd);
    end
  endtask

  task automatic test_truncated();
    bq_t p1 = '{8'h01, 8'h00};
    bq_t p2 = '{8'h01, 8'h01, 8'h00, 8'h5A, 8'hA5};
    allow_mode = 0; clr_mon(); model_pkt(p1); model_pkt(p2);
    send_pkt(p1, 0); send_pkt(p2, 0); wait_idle();
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL trunc_n: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL trunc[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++;
    if (err_seen != exp_err || cmd_count !== 8'(exp_cmd)) begin
      n_bad++; $display("FAIL trunc_status: err=%0d cnt=%0d want %0d/%0d", err_seen, cmd_count, exp_err, exp_cmd);
    end
  endtask

  task automatic test_random();
    bq_t p;
    int k, len;
    allow_mode = 1; clr_mon();
    for (int n = 0; n < 40; n++) begin
      p.delete();
      k = $urandom_range(0, 9);
      if (k <= 3) begin
        p = '{8'h01, 8'($urandom), 8'($urandom)};
        len = $urandom_range(1, 5);
        for (int j = 0; j < len; j++) p.push_back(8'($urandom));
      end else if (k <= 5 || k == 9) begin
        p = '{8'h02, 8'($urandom), 8'($urandom), {5'($urandom), 3'b000},
              (k == 9) ? 8'h00 : 8'($urandom_range(0, 12)), 8'($urandom)};
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) p.push_back(8'($urandom));
      end else if (k == 6) begin
        p = '{8'($urandom_range(4, 255))};
        repeat ($urandom_range(0, 2)) p.push_back(8'($urandom));
      end else if (k == 7) begin
        p = '{8'($urandom_range(1, 2))};
        len = (p[0] == 8'h01) ? $urandom_range(0, 2) : $urandom_range(0, 4);
        repeat (len) p.push_back(8'($urandom));
      end else begin
        p = '{8'h03};
        repeat ($urandom_range(1, 2)) p.push_back(8'($urandom));
      end
      model_pkt(p);
      send_pkt(p, 2);
    end
    wait_idle();
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL rand_n: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rand[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++;
    if (err_seen != exp_err) begin n_bad++; $display("FAIL rand_err: got %0d want %0d", err_seen, exp_err); end
    n_cmp++;
    if (cmd_count !== 8'(exp_cmd)) begin n_bad++; $display("FAIL rand_count: got %0d want %0d", cmd_count, 8'(exp_cmd)); end
    n_cmp++;
    if (viol != 0) begin n_bad++; $display("FAIL rand_gating: got %0d writes while blanked want 0", viol); end
  endtask

  task automatic test_sat_reset();
    bq_t p = '{8'h02, 8'h00, 8'h00, 8'h07, 8'hFF, 8'hAA};
    int t = 0;
    allow_mode = 0; clr_mon(); model_pkt(p);
    send_pkt(p, 0); wait_idle();
    n_cmp++;
    if (got_q.size() !== 1024) begin n_bad++; $display("FAIL sat_n: got %0d want 1024", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL sat[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_cmp++;
    if (cmd_count !== 8'(exp_cmd)) begin n_bad++; $display("FAIL sat_count: got %0d want %0d", cmd_count, exp_cmd); end
    clr_mon();
    send_pkt(p, 0);
    while (got_q.size() < 500 && t < 3000) begin @(posedge clk); #1; t++; end
    n_cmp++;
    if (got_q.size() != 500) begin n_bad++; $display("FAIL rst_point: got %0d writes want 500", got_q.size()); end
    rst = 1'b0; exp_cmd = 0;
    #1;
    n_cmp++;
    if ({ram_we, busy, err, in_ready, cmd_count} !== 12'd0) begin
      n_bad++; $display("FAIL mid_reset: we=%b busy=%b err=%b rdy=%b cnt=%0d want all 0", ram_we, busy, err, in_ready, cmd_count);
    end
    @(posedge clk); #1;
    rst = 1'b1; got_q.delete();
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || got_q.size() != 0) begin
      n_bad++; $display("FAIL post_reset: rdy=%b busy=%b writes=%0d want 1/0/0", in_ready, busy, got_q.size());
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_write();
    test_fill_wrap();
    test_clear_gated();
    test_bad_opcode();
    test_truncated();
    test_random();
    test_sat_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end
endmodule
